// File: rtl/tessia_pkg.sv
// Shared types and constants for the data-memory arbiter.
package tessia_pkg;

  typedef enum logic {ARB, BURST} arb_state_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VGA} rsp_tag_t;

  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// VGA burst address walker: latches base+stride at grant, steps one word per
// beat and flags the final beat of the burst.
module burst_addr_gen
  import tessia_pkg::*;
#(
  parameter int AW        = 32,
  parameter int BURST_LEN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_beat_o
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [AW-1:0]  addr_q, addr_d;
  logic [BCW-1:0] beat_q, beat_d;

  assign addr_o      = addr_q;
  assign last_beat_o = (beat_q == BCW'(BURST_LEN - 1));

  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (start_i) begin
      // beat 0 goes out directly from base_i, so the walker starts at beat 1
      addr_d = base_i + AW'(WORD_STRIDE);
      beat_d = BCW'(1);
    end else if (step_i) begin
      addr_d = addr_q + AW'(WORD_STRIDE);
      beat_d = last_beat_o ? '0 : beat_q + BCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DataMemory arbiter: CPU has fixed priority, the VGA reader gets
// uninterruptible bursts and a forced grant after MAX_WAIT lost cycles.
module dmem_arbiter
  import tessia_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_base,
  output logic          vga_grant,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  arb_state_t     state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  rsp_tag_t       tag_q, tag_d;
  logic           last_q, last_d;
  logic [DW-1:0]  cpu_hold_q, vga_hold_q;

  logic           grant, cpu_issue, burst_issue, last_beat;
  logic [AW-1:0]  burst_addr;

  burst_addr_gen #(.AW(AW), .BURST_LEN(BURST_LEN)) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .start_i     (grant),
    .base_i      (vga_base),
    .step_i      (burst_issue),
    .addr_o      (burst_addr),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    tag_d       = TAG_NONE;
    last_d      = 1'b0;
    grant       = 1'b0;
    cpu_issue   = 1'b0;
    burst_issue = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    // reset gates every issue so nothing reaches memory while it is held
    if (!reset) begin
      case (state_q)
        ARB: begin
          if (vga_req && (!cpu_req || wait_q == WCW'(MAX_WAIT))) begin
            grant    = 1'b1;
            mem_addr = vga_base;
            wait_d   = '0;
            tag_d    = TAG_VGA;
            last_d   = (BURST_LEN == 1);
            if (BURST_LEN > 1) state_d = BURST;
          end else if (cpu_req) begin
            cpu_issue = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) tag_d = TAG_CPU;
            if (vga_req && wait_q != WCW'(MAX_WAIT)) wait_d = wait_q + WCW'(1);
          end
        end
        BURST: begin
          burst_issue = 1'b1;
          mem_addr    = burst_addr;
          tag_d       = TAG_VGA;
          last_d      = last_beat;
          if (last_beat) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign vga_grant  = grant;
  assign cpu_stall  = !reset && cpu_req && (state_q == BURST || grant);
  assign cpu_rvalid = !reset && (tag_q == TAG_CPU);
  assign vga_rvalid = !reset && (tag_q == TAG_VGA);
  assign vga_done   = vga_rvalid && last_q;
  assign cpu_rdata  = reset ? '0 : (tag_q == TAG_CPU) ? mem_rdata : cpu_hold_q;
  assign vga_rdata  = reset ? '0 : (tag_q == TAG_VGA) ? mem_rdata : vga_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      wait_q     <= '0;
      tag_q      <= TAG_NONE;
      last_q     <= 1'b0;
      cpu_hold_q <= '0;
      vga_hold_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      if (tag_q == TAG_CPU) cpu_hold_q <= mem_rdata;
      if (tag_q == TAG_VGA) vga_hold_q <= mem_rdata;
    end
  end

endmodule
